idma_chan_dispatch: RTL

IDMA_CHAN_DISPATCH -- requirements
Module: idma_chan_dispatch

---
 rtl/idma_chan_dispatch.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/idma_chan_dispatch.sv
// idma_chan_dispatch: per-channel job FIFOs feeding one backend via a registered
// round-robin grant, with an in-order completion FIFO that routes done pulses
// and per-channel completion counters back to the issuing channel.
// Optional feature macro: IDMA_CHAN_DISPATCH_PRIO_EN (adds chan_prio_i, two-class priority).
module idma_chan_dispatch #(
  parameter int unsigned NumChan      = 4,
  parameter int unsigned JobFifoDepth = 2,
  parameter int unsigned OrderDepth   = 8,
  parameter type         idma_req_t   = logic
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  idma_req_t               chan_req_i [NumChan],
  input  logic [NumChan-1:0]      chan_valid_i,
  output logic [NumChan-1:0]      chan_ready_o,
`ifdef IDMA_CHAN_DISPATCH_PRIO_EN
  input  logic [NumChan-1:0]      chan_prio_i,
`endif
  output idma_req_t               be_req_o,
  output logic                    be_valid_o,
  input  logic                    be_ready_i,
  input  logic                    be_rsp_valid_i,
  output logic [NumChan-1:0]      chan_done_o,
  output logic [NumChan-1:0]      chan_busy_o,
  output logic [NumChan-1:0][31:0] chan_done_cnt_o,
  output logic                    err_o
);

  localparam int unsigned ChanW = (NumChan > 1) ? $clog2(NumChan) : 1;
  localparam int unsigned FPtrW = $clog2(JobFifoDepth);
  localparam int unsigned FCntW = FPtrW + 1;
  localparam int unsigned OPtrW = $clog2(OrderDepth);
  localparam int unsigned OCntW = OPtrW + 1;

  idma_req_t             fifo_mem_q [NumChan][JobFifoDepth];
  logic [FPtrW-1:0]      fifo_wr_q  [NumChan];
  logic [FPtrW-1:0]      fifo_rd_q  [NumChan];
  logic [FCntW-1:0]      fifo_cnt_q [NumChan];
  logic [ChanW-1:0]      ord_mem_q  [OrderDepth];
  logic [OPtrW-1:0]      ord_wr_q, ord_rd_q;
  logic [OCntW-1:0]      ord_cnt_q, ord_cnt_d;
  logic                  gnt_valid_q, gnt_valid_d;
  logic [ChanW-1:0]      gnt_idx_q, gnt_idx_d;
  idma_req_t             be_req_q, be_req_d;
  logic [ChanW-1:0]      rr_q, rr_d;
  logic                  err_q;
  logic [NumChan-1:0][31:0] done_cnt_q;

  logic [NumChan-1:0]    push, pop, elig, cand;
  logic                  hs, ord_pop, found;
  logic [ChanW-1:0]      sel, ord_head;

  assign hs        = gnt_valid_q & be_ready_i;
  assign ord_head  = ord_mem_q[ord_rd_q];
  assign ord_pop   = be_rsp_valid_i & (ord_cnt_q != '0);
  assign ord_cnt_d = ord_cnt_q + OCntW'(hs) - OCntW'(ord_pop);
  assign rr_d      = !hs ? rr_q :
                     (gnt_idx_q == ChanW'(NumChan - 1)) ? '0 : gnt_idx_q + ChanW'(1);

  // Channel FIFO handshakes; eligibility ignores this cycle's pushes (no fall-through)
  always_comb begin
    chan_ready_o = '0;
    push         = '0;
    pop          = '0;
    elig         = '0;
    for (int unsigned c = 0; c < NumChan; c++) begin
      chan_ready_o[c] = rst_ni && (fifo_cnt_q[c] != FCntW'(JobFifoDepth));
      push[c]         = chan_valid_i[c] && chan_ready_o[c];
      pop[c]          = hs && (gnt_idx_q == ChanW'(c));
      elig[c]         = pop[c] ? (fifo_cnt_q[c] > FCntW'(1)) : (fifo_cnt_q[c] != '0);
    end
  end

  // Round-robin search from rr_d over the (priority-filtered) eligible set
  always_comb begin
    int unsigned idx;
    idx   = 0;
    cand  = elig;
`ifdef IDMA_CHAN_DISPATCH_PRIO_EN
    if ((elig & chan_prio_i) != '0) cand = elig & chan_prio_i;
`endif
    found = 1'b0;
    sel   = rr_d;
    for (int unsigned i = 0; i < NumChan; i++) begin
      idx = 32'(rr_d) + i;
      if (idx >= NumChan) idx = idx - NumChan;
      if (!found && cand[ChanW'(idx)]) begin
        found = 1'b1;
        sel   = ChanW'(idx);
      end
    end
  end

  // Grant register reloads only when idle or on handshake, so it holds while stalled
  always_comb begin
    gnt_valid_d = gnt_valid_q;
    gnt_idx_d   = gnt_idx_q;
    be_req_d    = be_req_q;
    if (!gnt_valid_q || hs) begin
      gnt_valid_d = found && (ord_cnt_d < OCntW'(OrderDepth));
      if (found) begin
        gnt_idx_d = sel;
        be_req_d  = fifo_mem_q[sel][fifo_rd_q[sel] + FPtrW'(pop[sel])];
      end
    end
  end

  // Completion routing and busy tracking from the order FIFO contents
  always_comb begin
    chan_done_o = '0;
    chan_busy_o = '0;
    if (ord_pop) chan_done_o[ord_head] = 1'b1;
    for (int unsigned c = 0; c < NumChan; c++) chan_busy_o[c] = (fifo_cnt_q[c] != '0);
    for (int unsigned i = 0; i < OrderDepth; i++) begin
      if (OCntW'(i) < ord_cnt_q) chan_busy_o[ord_mem_q[ord_rd_q + OPtrW'(i)]] = 1'b1;
    end
  end

  // Storage arrays carry no reset; validity comes from the pointers/counts
  always_ff @(posedge clk_i) begin
    for (int unsigned c = 0; c < NumChan; c++) begin
      if (push[c]) fifo_mem_q[c][fifo_wr_q[c]] <= chan_req_i[c];
    end
    if (hs) ord_mem_q[ord_wr_q] <= gnt_idx_q;
  end

  // Control state: pointers, counts, grant, round-robin pointer, counters, error flag
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned c = 0; c < NumChan; c++) begin
        fifo_wr_q[c]  <= '0;
        fifo_rd_q[c]  <= '0;
        fifo_cnt_q[c] <= '0;
      end
      ord_wr_q    <= '0;
      ord_rd_q    <= '0;
      ord_cnt_q   <= '0;
      gnt_valid_q <= 1'b0;
      gnt_idx_q   <= '0;
      be_req_q    <= '0;
      rr_q        <= '0;
      err_q       <= 1'b0;
      done_cnt_q  <= '0;
    end else begin
      for (int unsigned c = 0; c < NumChan; c++) begin
        if (push[c]) fifo_wr_q[c] <= fifo_wr_q[c] + FPtrW'(1);
        if (pop[c])  fifo_rd_q[c] <= fifo_rd_q[c] + FPtrW'(1);
        fifo_cnt_q[c] <= fifo_cnt_q[c] + FCntW'(push[c]) - FCntW'(pop[c]);
        if (ord_pop && (ord_head == ChanW'(c))) done_cnt_q[c] <= done_cnt_q[c] + 32'd1;
      end
      if (hs)      ord_wr_q <= ord_wr_q + OPtrW'(1);
      if (ord_pop) ord_rd_q <= ord_rd_q + OPtrW'(1);
      ord_cnt_q   <= ord_cnt_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_idx_q   <= gnt_idx_d;
      be_req_q    <= be_req_d;
      rr_q        <= rr_d;
      if (be_rsp_valid_i && !ord_pop) err_q <= 1'b1;
    end
  end

  assign be_valid_o      = gnt_valid_q;
  assign be_req_o        = be_req_q;
  assign err_o           = err_q;
  assign chan_done_cnt_o = done_cnt_q;

endmodule
